puf_resp_collector: RTL and testbench

//  Parametrised successor to the 8-bit arbiter-PUF response shifter. Collects RESP_WIDTH

---
 rtl/puf_pkg.sv | 18 +
 rtl/puf_majority_voter.sv | 55 +++++
 rtl/puf_resp_collector.sv | 136 +++++++++++++
 tb/tb_puf_resp_collector.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared definitions for the arbiter-PUF response collector: FSM state encoding
// and the vote-count limit.
package puf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_REARM = 2'd2,
    ST_DONE  = 2'd3
  } puf_state_e;

  localparam int PUF_MAX_VOTES = 15;

  function automatic bit puf_votes_ok(input int votes);
    return (votes >= 1) && (votes <= PUF_MAX_VOTES) && ((votes % 2) == 1);
  endfunction

endpackage

// File: rtl/puf_majority_voter.sv
// Temporal majority voter: counts the arbiter decisions of one response bit and
// reports the voted bit and whether every evaluation agreed.
module puf_majority_voter
  import puf_pkg::*;
#(
  parameter int VOTES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_record,
  input  logic i_result,
  output logic o_last,
  output logic o_bit,
  output logic o_stable
);

  localparam int CW = $clog2(VOTES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(VOTES - 1);
  localparam logic [CW-1:0] HALF     = CW'(VOTES / 2);
  localparam logic [CW-1:0] ALL      = CW'(VOTES);

  if (!puf_votes_ok(VOTES)) begin : g_bad_votes
    $error("puf_majority_voter: VOTES must be odd and within 1..15");
  end

  logic [CW-1:0] r_vote_idx;
  logic [CW-1:0] r_ones_cnt;
  logic [CW-1:0] w_ones_incl;

  // Decision includes the vote being recorded this cycle.
  assign w_ones_incl = r_ones_cnt + CW'(i_result);
  assign o_last      = (r_vote_idx == LAST_IDX);
  assign o_bit       = (w_ones_incl > HALF);
  assign o_stable    = (w_ones_incl == '0) || (w_ones_incl == ALL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vote_idx <= '0;
      r_ones_cnt <= '0;
    end else if (i_clear) begin
      r_vote_idx <= '0;
      r_ones_cnt <= '0;
    end else if (i_record) begin
      if (o_last) begin
        r_vote_idx <= '0;
        r_ones_cnt <= '0;
      end else begin
        r_vote_idx <= r_vote_idx + 1'b1;
        r_ones_cnt <= w_ones_incl;
      end
    end
  end

endmodule

// File: rtl/puf_resp_collector.sv
// Arbiter-PUF response collector: sequences arbiter re-arming, majority-votes each
// bit, shifts the result into the response and hands it off via valid/ack.
module puf_resp_collector
  import puf_pkg::*;
#(
  parameter int RESP_WIDTH = 8,
  parameter int VOTES      = 1,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  arbiter_result,
  input  logic                  arbiter_done,
  output logic                  arb_rst,
  output logic                  busy,
  output logic [RESP_WIDTH-1:0] response,
  output logic [RESP_WIDTH-1:0] stable_mask,
  output logic                  resp_valid,
  input  logic                  resp_ack
);

  localparam int BW = $clog2(RESP_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(RESP_WIDTH - 1);

  if (RESP_WIDTH < 2 || RESP_WIDTH > 64) begin : g_bad_width
    $error("puf_resp_collector: RESP_WIDTH must be within 2..64");
  end

  puf_state_e            r_state;
  puf_state_e            w_state_nxt;
  logic [BW-1:0]         r_bit_idx;
  logic [RESP_WIDTH-1:0] r_response;
  logic [RESP_WIDTH-1:0] r_stable_mask;
  logic                  r_resp_valid;
  logic                  r_busy;
  logic                  r_arb_rst;
  logic                  w_clear;
  logic                  w_record;
  logic                  w_shift;
  logic                  w_last_vote;
  logic                  w_bit;
  logic                  w_stable;

  function automatic logic [RESP_WIDTH-1:0] shift_in(input logic [RESP_WIDTH-1:0] cur,
                                                     input logic                  b);
    if (MSB_FIRST != 0) return {cur[RESP_WIDTH-2:0], b};
    else                return {b, cur[RESP_WIDTH-1:1]};
  endfunction

  puf_majority_voter #(
    .VOTES(VOTES)
  ) u_voter (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_record(w_record),
    .i_result(arbiter_result),
    .o_last  (w_last_vote),
    .o_bit   (w_bit),
    .o_stable(w_stable)
  );

  assign w_shift = w_record & w_last_vote;

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_record    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_WAIT;
          w_clear     = 1'b1;
        end
      end
      ST_WAIT: begin
        if (arbiter_done) begin
          w_record    = 1'b1;
          w_state_nxt = (w_last_vote && (r_bit_idx == LAST_BIT)) ? ST_DONE : ST_REARM;
        end
      end
      ST_REARM: w_state_nxt = ST_WAIT;
      ST_DONE: begin
        // Ack together with start restarts without passing through IDLE.
        if (resp_ack) begin
          if (start) begin
            w_state_nxt = ST_WAIT;
            w_clear     = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_arb_rst    <= 1'b1;
      r_busy       <= 1'b0;
      r_resp_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_arb_rst    <= (w_state_nxt != ST_WAIT);
      r_busy       <= (w_state_nxt == ST_WAIT) || (w_state_nxt == ST_REARM);
      r_resp_valid <= (w_state_nxt == ST_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_idx     <= '0;
      r_response    <= '0;
      r_stable_mask <= '0;
    end else if (w_clear) begin
      r_bit_idx     <= '0;
      r_response    <= '0;
      r_stable_mask <= '0;
    end else if (w_shift) begin
      r_response    <= shift_in(r_response, w_bit);
      r_stable_mask <= shift_in(r_stable_mask, w_stable);
      if (r_bit_idx != LAST_BIT) r_bit_idx <= r_bit_idx + 1'b1;
    end
  end

  assign arb_rst     = r_arb_rst;
  assign busy        = r_busy;
  assign resp_valid  = r_resp_valid;
  assign response    = r_response;
  assign stable_mask = r_stable_mask;

endmodule

// File: tb/tb_puf_resp_collector.sv
// Bench for puf_resp_collector: three instances (V=1 MSB-first, V=3 MSB-first,
// V=1 LSB-first) driven by directed and random vote streams against a counting model.
module tb_puf_resp_collector;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start_i [3];
  logic         ares_i  [3];
  logic         adone_i [3];
  logic         ack_i   [3];
  logic         arst_o  [3];
  logic         busy_o  [3];
  logic         rv_o    [3];
  logic [W-1:0] resp_o  [3];
  logic [W-1:0] smask_o [3];

  bit vote_mem [W][15];
  int n_assert = 0;
  int n_fail   = 0;

  puf_resp_collector #(.RESP_WIDTH(W), .VOTES(1), .MSB_FIRST(1)) u0 (
    .clk(clk), .rst(rst), .start(start_i[0]), .arbiter_result(ares_i[0]),
    .arbiter_done(adone_i[0]), .arb_rst(arst_o[0]), .busy(busy_o[0]),
    .response(resp_o[0]), .stable_mask(smask_o[0]), .resp_valid(rv_o[0]),
    .resp_ack(ack_i[0]));

  puf_resp_collector #(.RESP_WIDTH(W), .VOTES(3), .MSB_FIRST(1)) u1 (
    .clk(clk), .rst(rst), .start(start_i[1]), .arbiter_result(ares_i[1]),
    .arbiter_done(adone_i[1]), .arb_rst(arst_o[1]), .busy(busy_o[1]),
    .response(resp_o[1]), .stable_mask(smask_o[1]), .resp_valid(rv_o[1]),
    .resp_ack(ack_i[1]));

  puf_resp_collector #(.RESP_WIDTH(W), .VOTES(1), .MSB_FIRST(0)) u2 (
    .clk(clk), .rst(rst), .start(start_i[2]), .arbiter_result(ares_i[2]),
    .arbiter_done(adone_i[2]), .arb_rst(arst_o[2]), .busy(busy_o[2]),
    .response(resp_o[2]), .stable_mask(smask_o[2]), .resp_valid(rv_o[2]),
    .resp_ack(ack_i[2]));

  function automatic int nv_of(input int u);
    return (u == 1) ? 3 : 1;
  endfunction

  function automatic bit msb_of(input int u);
    return (u != 2);
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  // Reference: count ones per bit, majority by arithmetic, place bit by arrival order.
  task automatic model(input int u, output logic [7:0] er, output logic [7:0] es);
    int ones;
    int pos;
    er = '0;
    es = '0;
    for (int b = 0; b < W; b++) begin
      ones = 0;
      for (int v = 0; v < nv_of(u); v++) ones += int'(vote_mem[b][v]);
      pos = msb_of(u) ? (W - 1 - b) : b;
      er[pos] = (2 * ones > nv_of(u));
      es[pos] = (ones == 0) || (ones == nv_of(u));
    end
  endtask

  task automatic fill_random();
    int mode;
    for (int b = 0; b < W; b++) begin
      mode = int'($urandom_range(0, 2));
      for (int v = 0; v < 15; v++)
        vote_mem[b][v] = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  endtask

  task automatic set_stream(input logic [7:0] bits_first_to_last);
    logic [7:0] s;
    s = bits_first_to_last;
    for (int b = 0; b < W; b++) begin
      for (int v = 0; v < 15; v++) vote_mem[b][v] = 1'b0;
      vote_mem[b][0] = s[7-b];
    end
  endtask

  task automatic check_reset(input string tag);
    for (int u = 0; u < 3; u++) begin
      chk1({tag, "_valid"}, rv_o[u], 1'b0);
      chk1({tag, "_busy"}, busy_o[u], 1'b0);
      chk1({tag, "_arb_rst"}, arst_o[u], 1'b1);
      chk8({tag, "_resp"}, resp_o[u], 8'h00);
      chk8({tag, "_mask"}, smask_o[u], 8'h00);
    end
  endtask

  task automatic pulse_start(input int u);
    start_i[u] = 1'b1;
    @(negedge clk);
    start_i[u] = 1'b0;
  endtask

  task automatic feed(input int u, input int nbits, input bit glitch);
    int  t;
    bit  is_last;
    for (int b = 0; b < nbits; b++) begin
      for (int v = 0; v < nv_of(u); v++) begin
        t = 0;
        while (arst_o[u] !== 1'b0 && t < 20) begin
          @(negedge clk);
          t++;
        end
        chk1("wait_timeout", (t < 20), 1'b1);
        adone_i[u] = 1'b1;
        ares_i[u]  = vote_mem[b][v];
        start_i[u] = glitch;
        @(negedge clk);
        start_i[u] = 1'b0;
        is_last = (b == W - 1) && (v == nv_of(u) - 1);
        if (glitch && !is_last) begin
          chk1("rearm_arb_rst", arst_o[u], 1'b1);
          chk1("rearm_busy", busy_o[u], 1'b1);
          ares_i[u] = 1'($urandom_range(0, 1));
          @(negedge clk);
          adone_i[u] = 1'b0;
          chk1("rearm_one_cycle", arst_o[u], 1'b0);
        end else begin
          adone_i[u] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_done(input string tag, input int u,
                            input logic [7:0] er, input logic [7:0] es);
    chk1({tag, "_valid"}, rv_o[u], 1'b1);
    chk1({tag, "_busy"}, busy_o[u], 1'b0);
    chk1({tag, "_arb_rst"}, arst_o[u], 1'b1);
    chk8({tag, "_resp"}, resp_o[u], er);
    chk8({tag, "_mask"}, smask_o[u], es);
  endtask

  task automatic ack_only(input int u);
    ack_i[u] = 1'b1;
    @(negedge clk);
    ack_i[u] = 1'b0;
    chk1("ack_valid_drop", rv_o[u], 1'b0);
    chk1("ack_busy", busy_o[u], 1'b0);
  endtask

  task automatic random_run(input string tag, input int u, input bit glitch);
    logic [7:0] er, es;
    fill_random();
    pulse_start(u);
    feed(u, W, glitch);
    model(u, er, es);
    check_done(tag, u, er, es);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] er, es;
    rst = 1'b1;
    for (int u = 0; u < 3; u++) begin
      start_i[u] = 1'b0; ares_i[u] = 1'b0; adone_i[u] = 1'b0; ack_i[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed: V=1 MSB-first, then LSB-first, same stream
    set_stream(8'b1011_0010);
    pulse_start(0);
    feed(0, W, 1'b0);
    check_done("t1", 0, 8'hB2, 8'hFF);
    set_stream(8'b1011_0010);
    pulse_start(2);
    feed(2, W, 1'b0);
    check_done("t3", 2, 8'h4D, 8'hFF);
    ack_only(2);

    // Directed: V=3, first bit split 1,1,0
    set_stream(8'h00);
    vote_mem[0][0] = 1'b1; vote_mem[0][1] = 1'b1; vote_mem[0][2] = 1'b0;
    pulse_start(1);
    feed(1, W, 1'b0);
    check_done("t2", 1, 8'h80, 8'h7F);
    model(1, er, es);
    chk8("t2_model_resp", resp_o[1], er);
    ack_only(1);

    // Held valid, then ack+start together
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk1("t4_hold_valid", rv_o[0], 1'b1);
      chk8("t4_hold_resp", resp_o[0], 8'hB2);
    end
    ack_i[0] = 1'b1;
    start_i[0] = 1'b1;
    @(negedge clk);
    ack_i[0] = 1'b0;
    start_i[0] = 1'b0;
    chk1("t4_busy", busy_o[0], 1'b1);
    chk1("t4_valid", rv_o[0], 1'b0);
    chk8("t4_resp", resp_o[0], 8'h00);
    chk1("t4_arb_rst", arst_o[0], 1'b0);
    fill_random();
    feed(0, W, 1'b0);
    model(0, er, es);
    check_done("t4_run", 0, er, es);
    ack_only(0);

    // Reset mid-collection, then a full collection
    fill_random();
    pulse_start(0);
    feed(0, 3, 1'b0);
    rst = 1'b1;
    #1;
    check_reset("t5_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    random_run("t5_run", 0, 1'b0);
    ack_only(0);

    // Ignored events: start in WAIT, done in REARM/DONE, start without ack, ack in IDLE
    random_run("t6_run", 1, 1'b1);
    model(1, er, es);
    adone_i[1] = 1'b1;
    ares_i[1]  = ~er[0];
    start_i[1] = 1'b1;
    @(negedge clk);
    adone_i[1] = 1'b0;
    start_i[1] = 1'b0;
    check_done("t6_done_glitch", 1, er, es);
    ack_only(1);
    ack_i[1] = 1'b1;
    adone_i[1] = 1'b1;
    @(negedge clk);
    ack_i[1] = 1'b0;
    adone_i[1] = 1'b0;
    chk1("t6_idle_busy", busy_o[1], 1'b0);
    chk1("t6_idle_arb_rst", arst_o[1], 1'b1);
    chk1("t6_idle_valid", rv_o[1], 1'b0);

    // Extra random collections across configurations
    for (int k = 0; k < 4; k++) begin
      random_run("rand", (k % 2) + 1, bit'(k >= 2));
      ack_only((k % 2) + 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
